mem_arbiter: RTL and testbench

- Sequences the single byte-wide RAM/IO port between two requesters: instruction fetch (IF, 4-byte reads) and the load/store stage (MEM, 1/2/4-byte reads and writes).
- Sits between the fetch/memory-access stages and the top-level mem_din/mem_dout/mem_a/mem_wr pins.
- Serialises multi-byte accesses little-endian, honours the 1-cycle RAM read latency and UART back-pressure.
- Supports aborting an in-flight fetch on a jump.

---
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single byte-wide RAM/IO port between instruction fetch and
// load/store, serialising multi-byte accesses little-endian around the 1-cycle read latency.
module mem_arbiter #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    input  logic              io_buffer_full,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IF_RD,
        S_MEM_RD,
        S_MEM_WR
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ADDR_W-1:0] r_base;
    logic [1:0]        r_last;      // beat count minus one
    logic [1:0]        r_idx;       // beat currently on the bus
    logic [1:0]        r_capt;      // next byte to capture
    logic              r_active;    // bus carries a real read beat (not capture-only)
    logic              r_valid;     // ram_din holds byte r_capt this cycle
    logic              r_rewind;    // a stall happened; re-issue from r_capt
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;
    logic [31:0]       r_if_inst;
    logic [31:0]       r_mem_rdata;
    logic              r_if_done;
    logic              r_mem_done;

    logic              w_rd;
    logic              w_rewind;
    logic [1:0]        w_idx;
    logic              w_active;
    logic              w_valid;
    logic [ADDR_W-1:0] w_addr;
    logic              w_io_stall;
    logic              w_flush;
    logic              w_rd_last;
    logic              w_wr_beat;
    logic              w_wr_last;
    logic              w_acc_mem;
    logic              w_acc_if;
    logic [1:0]        w_len_last;
    logic [31:0]       w_buf_next;

    // NOTE: every signal gets a value before any condition, so no latch can be inferred.
    always_comb begin
        w_rd       = (r_state == S_IF_RD) || (r_state == S_MEM_RD);
        w_rewind   = r_rewind && rdy;
        w_idx      = w_rewind ? r_capt : r_idx;
        w_active   = w_rewind || r_active;
        w_valid    = r_valid && !w_rewind;
        w_addr     = r_base + ADDR_W'(w_idx);
        w_io_stall = (w_addr[17:16] == IO_SEL) && io_buffer_full;
        w_flush    = (r_state == S_IF_RD) && if_flush;
        w_rd_last  = w_rd && w_valid && (r_capt == r_last);
        w_wr_beat  = (r_state == S_MEM_WR) && !w_io_stall;
        w_wr_last  = w_wr_beat && (r_idx == r_last);
        // A requester whose done is showing is not re-accepted in that same cycle.
        w_acc_mem  = (r_state == S_IDLE) && mem_req && !r_mem_done;
        w_acc_if   = (r_state == S_IDLE) && !w_acc_mem && if_req && !if_flush && !r_if_done;
        w_len_last = (mem_len == 2'd0) ? 2'd0 : (mem_len == 2'd1) ? 2'd1 : 2'd3;
        w_buf_next = r_buf;
        w_buf_next[{r_capt, 3'b000} +: 8] = ram_din;
    end

    always_comb begin
        w_state_next = r_state;
        if (rdy) begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc_mem)
                        w_state_next = mem_we ? S_MEM_WR : S_MEM_RD;
                    else if (w_acc_if)
                        w_state_next = S_IF_RD;
                end
                S_IF_RD:  if (w_flush || w_rd_last) w_state_next = S_IDLE;
                S_MEM_RD: if (w_rd_last) w_state_next = S_IDLE;
                S_MEM_WR: if (w_wr_last) w_state_next = S_IDLE;
                default:  w_state_next = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base      <= '0;
            r_last      <= '0;
            r_idx       <= '0;
            r_capt      <= '0;
            r_active    <= 1'b0;
            r_valid     <= 1'b0;
            r_rewind    <= 1'b0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_if_inst   <= '0;
            r_mem_rdata <= '0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
        end else if (!rdy) begin
            if (w_rd)
                r_rewind <= 1'b1;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            r_rewind   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_acc_mem || w_acc_if) begin
                        r_base   <= w_acc_mem ? mem_addr : if_addr;
                        r_last   <= w_acc_mem ? w_len_last : 2'd3;
                        r_wdata  <= mem_wdata;
                        r_idx    <= '0;
                        r_capt   <= '0;
                        r_active <= 1'b1;
                        r_valid  <= 1'b0;
                        r_buf    <= '0;
                    end
                end
                S_IF_RD, S_MEM_RD: begin
                    if (!w_flush) begin
                        r_valid <= w_active;
                        if (w_valid) begin
                            r_buf  <= w_buf_next;
                            r_capt <= r_capt + 2'd1;
                        end
                        if (w_rd_last) begin
                            if (r_state == S_IF_RD) begin
                                r_if_inst <= w_buf_next;
                                r_if_done <= 1'b1;
                            end else begin
                                r_mem_rdata <= w_buf_next;
                                r_mem_done  <= 1'b1;
                            end
                        end else if (w_active && (w_idx != r_last)) begin
                            r_idx    <= w_idx + 2'd1;
                            r_active <= 1'b1;
                        end else begin
                            r_idx    <= w_idx;
                            r_active <= 1'b0;
                        end
                    end
                end
                S_MEM_WR: begin
                    if (w_wr_last)
                        r_mem_done <= 1'b1;
                    else if (w_wr_beat)
                        r_idx <= r_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign ram_a     = w_addr;
    assign ram_dout  = r_wdata[{r_idx, 3'b000} +: 8];
    assign ram_wr    = (r_state == S_MEM_WR) && rdy && !w_io_stall;
    assign if_done   = r_if_done && !if_flush;
    assign mem_done  = r_mem_done;
    assign if_inst   = r_if_inst;
    assign mem_rdata = r_mem_rdata;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a byte RAM model with 1-cycle read latency answers the
// port, and each scenario checks bus activity and done pulses cycle by cycle.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        io_buffer_full;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_done;
    logic [31:0] if_inst;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        busy;

    logic [7:0]  ram [0:4095];
    int          n_vec = 0;
    int          n_err = 0;

    mem_arbiter #(.ADDR_W(32), .IO_SEL(2'b11)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .ram_din        (ram_din),
        .ram_dout       (ram_dout),
        .ram_a          (ram_a),
        .ram_wr         (ram_wr),
        .io_buffer_full (io_buffer_full),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_flush       (if_flush),
        .if_done        (if_done),
        .if_inst        (if_inst),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_len        (mem_len),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_done       (mem_done),
        .mem_rdata      (mem_rdata),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data for this cycle's address appears next cycle.
    always @(posedge clk) begin
        ram_din <= ram[ram_a[11:0]];
        if (ram_wr)
            ram[ram_a[11:0]] <= ram_dout;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_a;
        rst = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
        if_req = 1'b1; if_addr = 32'h100; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'd0; mem_addr = '0; mem_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({ram_a, ram_dout, ram_wr, if_done, mem_done, if_inst, mem_rdata, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: ram_a=%h dout=%h wr=%b ifd=%b memd=%b inst=%h rdata=%h busy=%b, all must be 0",
                     ram_a, ram_dout, ram_wr, if_done, mem_done, if_inst, mem_rdata, busy);
        end
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_a = (k <= 4) ? 32'h100 + 32'(k) - 32'd1 : 32'h103;
            if (k <= 5) begin
                n_vec++;
                if (ram_a !== exp_a) begin
                    n_err++; $display("FAIL reset_fetch_addr c%0d: got %h want %h", k, ram_a, exp_a);
                end
            end
            n_vec++;
            if (if_done !== (k == 6)) begin
                n_err++; $display("FAIL reset_fetch_done c%0d: got %b want %b", k, if_done, k == 6);
            end
            n_vec++;
            if (busy !== (k < 6)) begin
                n_err++; $display("FAIL reset_fetch_busy c%0d: got %b want %b", k, busy, k < 6);
            end
        end
        n_vec++;
        if (if_inst !== 32'h0000_0013) begin
            n_err++; $display("FAIL reset_fetch_inst: got %h want 00000013", if_inst);
        end
        if_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_a;
        step();
        n_vec++;
        if (if_done !== 1'b0) begin
            n_err++; $display("FAIL if_done_pulse_width: got %b want 0", if_done);
        end
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd2; mem_addr = 32'h200;
        if_req = 1'b1; if_addr = 32'h104;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) mem_addr = 32'h0;
            #1;
            exp_a = 32'h200 + 32'((k < 4) ? k : 4) - 32'd1;
            if (k <= 5) begin
                n_vec++;
                if (ram_a !== exp_a) begin
                    n_err++; $display("FAIL prio_mem_addr c%0d: got %h want %h", k, ram_a, exp_a);
                end
            end
            n_vec++;
            if ({mem_done, if_done} !== {(k == 6), 1'b0}) begin
                n_err++; $display("FAIL prio_mem_done c%0d: got %b%b want %b0", k, mem_done, if_done, k == 6);
            end
        end
        n_vec++;
        if (mem_rdata !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL prio_mem_rdata: got %h want deadbeef", mem_rdata);
        end
        mem_req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_a = 32'h104 + 32'((k < 4) ? k : 4) - 32'd1;
            if (k <= 5) begin
                n_vec++;
                if (ram_a !== exp_a || busy !== 1'b1) begin
                    n_err++; $display("FAIL handoff_if_addr c%0d: got %h busy %b want %h busy 1", k, ram_a, busy, exp_a);
                end
            end
            n_vec++;
            if (if_done !== (k == 6)) begin
                n_err++; $display("FAIL handoff_if_done c%0d: got %b want %b", k, if_done, k == 6);
            end
        end
        n_vec++;
        if (if_inst !== 32'h0001_0537) begin
            n_err++; $display("FAIL handoff_if_inst: got %h want 00010537", if_inst);
        end
        if_req = 1'b0;
    endtask

    task automatic test_store_half();
        logic [40:0] exp_bus [3];
        exp_bus = '{{32'h31, 8'hCD, 1'b1}, {32'h32, 8'hAB, 1'b1}, {32'h32, 8'hAB, 1'b0}};
        step();
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd1; mem_addr = 32'h31; mem_wdata = 32'h1234_ABCD;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k < 3) begin
                n_vec++;
                if ({ram_a, ram_dout, ram_wr} !== exp_bus[k-1]) begin
                    n_err++; $display("FAIL store_half_bus c%0d: got a=%h d=%h wr=%b want %h", k, ram_a, ram_dout, ram_wr, exp_bus[k-1]);
                end
            end else begin
                n_vec++;
                if (ram_wr !== 1'b0) begin
                    n_err++; $display("FAIL store_half_wr_after: got %b want 0", ram_wr);
                end
            end
            n_vec++;
            if (mem_done !== (k == 3)) begin
                n_err++; $display("FAIL store_half_done c%0d: got %b want %b", k, mem_done, k == 3);
            end
        end
        mem_req = 1'b0;
    endtask

    task automatic test_io_stall();
        step();
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd0; mem_addr = 32'h0003_0000; mem_wdata = 32'h41;
        io_buffer_full = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 4) io_buffer_full = 1'b0;
            #1;
            if (k <= 3) begin
                n_vec++;
                if ({ram_wr, mem_done, busy} !== 3'b001 || ram_a !== 32'h0003_0000) begin
                    n_err++; $display("FAIL io_stall_hold c%0d: got wr=%b done=%b busy=%b a=%h want 0 0 1 00030000", k, ram_wr, mem_done, busy, ram_a);
                end
            end else if (k == 4) begin
                n_vec++;
                if ({ram_wr, ram_dout, mem_done} !== {1'b1, 8'h41, 1'b0}) begin
                    n_err++; $display("FAIL io_stall_issue: got wr=%b d=%h done=%b want 1 41 0", ram_wr, ram_dout, mem_done);
                end
            end else begin
                n_vec++;
                if ({mem_done, ram_wr} !== 2'b10) begin
                    n_err++; $display("FAIL io_stall_done: got done=%b wr=%b want 1 0", mem_done, ram_wr);
                end
            end
        end
        mem_req = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] exp_a;
        step();
        if_req = 1'b1; if_addr = 32'h100;
        step();
        step();
        step();
        if_flush = 1'b1;
        #1;
        n_vec++;
        if ({if_done, busy} !== 2'b01) begin
            n_err++; $display("FAIL flush_cycle3: got done=%b busy=%b want 0 1", if_done, busy);
        end
        step();
        n_vec++;
        if ({if_done, busy} !== 2'b00) begin
            n_err++; $display("FAIL flush_idle_next: got done=%b busy=%b want 0 0", if_done, busy);
        end
        step();
        if_flush = 1'b0; if_addr = 32'h40;
        #1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL flush_in_idle_ignores_req: got busy=%b want 0", busy);
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_a = 32'h40 + 32'((k < 4) ? k : 4) - 32'd1;
            if (k <= 5) begin
                n_vec++;
                if (ram_a !== exp_a) begin
                    n_err++; $display("FAIL refetch_addr c%0d: got %h want %h", k, ram_a, exp_a);
                end
            end
            n_vec++;
            if (if_done !== (k == 6)) begin
                n_err++; $display("FAIL refetch_done c%0d: got %b want %b", k, if_done, k == 6);
            end
        end
        n_vec++;
        if (if_inst !== 32'h0010_0093) begin
            n_err++; $display("FAIL refetch_inst: got %h want 00100093", if_inst);
        end
        if_req = 1'b0;
    endtask

    task automatic test_rdy_load();
        int off [8] = '{0, 1, 2, 2, 1, 2, 3, 3};
        step();
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd2; mem_addr = 32'h200;
        for (int k = 1; k <= 9; k++) begin
            step();
            rdy = !(k == 3 || k == 4);
            #1;
            if (k <= 8) begin
                n_vec++;
                if (ram_a !== 32'h200 + 32'(off[k-1]) || ram_wr !== 1'b0) begin
                    n_err++; $display("FAIL rdy_load_bus c%0d: got a=%h wr=%b want %h 0", k, ram_a, ram_wr, 32'h200 + 32'(off[k-1]));
                end
            end
            n_vec++;
            if (mem_done !== (k == 9)) begin
                n_err++; $display("FAIL rdy_load_done c%0d: got %b want %b", k, mem_done, k == 9);
            end
        end
        n_vec++;
        if (mem_rdata !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL rdy_load_rdata: got %h want deadbeef", mem_rdata);
        end
        mem_req = 1'b0;
    endtask

    task automatic test_rdy_store();
        logic [40:0] exp_bus [5];
        exp_bus = '{{32'h50, 8'hD4, 1'b1}, {32'h51, 8'hC3, 1'b0}, {32'h51, 8'hC3, 1'b1},
                    {32'h52, 8'hB2, 1'b1}, {32'h53, 8'hA1, 1'b1}};
        step();
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h50; mem_wdata = 32'hA1B2_C3D4;
        for (int k = 1; k <= 6; k++) begin
            step();
            rdy = (k != 2);
            #1;
            if (k <= 5) begin
                n_vec++;
                if ({ram_a, ram_dout, ram_wr} !== exp_bus[k-1]) begin
                    n_err++; $display("FAIL rdy_store_bus c%0d: got a=%h d=%h wr=%b want %h", k, ram_a, ram_dout, ram_wr, exp_bus[k-1]);
                end
            end
            n_vec++;
            if (mem_done !== (k == 6)) begin
                n_err++; $display("FAIL rdy_store_done c%0d: got %b want %b", k, mem_done, k == 6);
            end
        end
        mem_req = 1'b0;
    endtask

    task automatic test_load_byte();
        step();
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h203;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k <= 2) begin
                n_vec++;
                if (ram_a !== 32'h203) begin
                    n_err++; $display("FAIL load_byte_addr c%0d: got %h want 00000203", k, ram_a);
                end
            end
            n_vec++;
            if (mem_done !== (k == 3)) begin
                n_err++; $display("FAIL load_byte_done c%0d: got %b want %b", k, mem_done, k == 3);
            end
        end
        n_vec++;
        if (mem_rdata !== 32'h0000_00DE) begin
            n_err++; $display("FAIL load_byte_zext: got %h want 000000de", mem_rdata);
        end
        mem_req = 1'b0;
    endtask

    task automatic test_len3_wrap();
        logic [31:0] exp_a;
        ram[12'hFFE] = 8'h11; ram[12'hFFF] = 8'h22; ram[12'h000] = 8'h33; ram[12'h001] = 8'h44;
        step();
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd3; mem_addr = 32'hFFFF_FFFE;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_a = 32'hFFFF_FFFE + 32'((k < 4) ? k : 4) - 32'd1;
            if (k <= 5) begin
                n_vec++;
                if (ram_a !== exp_a) begin
                    n_err++; $display("FAIL wrap_addr c%0d: got %h want %h", k, ram_a, exp_a);
                end
            end
            n_vec++;
            if (mem_done !== (k == 6)) begin
                n_err++; $display("FAIL len3_done c%0d: got %b want %b", k, mem_done, k == 6);
            end
        end
        n_vec++;
        if (mem_rdata !== 32'h4433_2211) begin
            n_err++; $display("FAIL len3_rdata: got %h want 44332211", mem_rdata);
        end
        mem_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h13;
        ram[12'h104] = 8'h37; ram[12'h105] = 8'h05; ram[12'h106] = 8'h01; ram[12'h107] = 8'h00;
        ram[12'h200] = 8'hEF; ram[12'h201] = 8'hBE; ram[12'h202] = 8'hAD; ram[12'h203] = 8'hDE;
        ram[12'h040] = 8'h93; ram[12'h041] = 8'h00; ram[12'h042] = 8'h10; ram[12'h043] = 8'h00;
        test_reset();
        test_back_to_back();
        test_store_half();
        test_io_stall();
        test_flush();
        test_rdy_load();
        test_rdy_store();
        test_load_byte();
        test_len3_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
